hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default 8, number of architectural registers; REG_AW = $clog2(REG_COUNT).
REQ-002 SHALL have parameter PIPE_DEPTH, default 3, number of in-flight slots after decode (slot0=EX, slot1=MEM, slot2=WB); FWD_W = $clog2(PIPE_DEPTH+1).
REQ-003 SHALL have parameter LOAD_FWD_SLOT, default 1, lowest slot index from which a load result is forwardable.
REQ-004 Ports: clk in 1 clock; rst in 1 reset, synchronous, active-high; one clock domain.
REQ-005 dec_valid in 1, decode holds a real instruction; dec_rsrc/dec_rdst in REG_AW, source registers; dec_rsrc_used/dec_rdst_used in 1, operand read.
REQ-006 dec_wr_en in 1, decode instruction writes a register; dec_wr_addr in REG_AW; dec_is_load in 1.
REQ-007 br_taken in 1, execute resolved a taken branch/jump; irq in 1, level interrupt request.
REQ-008 pc_write out 1, PC may advance; stall_fetch out 1; flush_fetch out 1; flush_decode out 1; bubble out 1, insert NOP into execute.
REQ-009 fwd_sel_src/fwd_sel_dst out FWD_W, 0 = register file, k+1 = result of slot k.
REQ-010 push_pc out 1; push_flags out 1; load_vector out 1; irq_ack out 1.

Function
REQ-011 SHALL keep PIPE_DEPTH slots {valid, addr, is_load}; each cycle slot k shifts to k+1, slot PIPE_DEPTH-1 retires.
REQ-012 Slot0 SHALL load {dec_wr_en, dec_wr_addr, dec_is_load} when dec_valid and no bubble/flush, else valid=0.
REQ-013 fwd_sel_x SHALL select the lowest-index valid slot whose addr equals the used source; 0 if none or operand unused.
REQ-014 If that slot is_load and k < LOAD_FWD_SLOT: load-use stall -- stall_fetch=1, pc_write=0, bubble=1, decode held.
REQ-015 br_taken SHALL assert flush_fetch and flush_decode same cycle; decode instruction not entered into slot0.
REQ-016 Priority: rst > br_taken flush > interrupt sequence > load-use stall.
REQ-017 FSM states IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR.
REQ-018 IDLE -> DRAIN when irq or irq_pending; DRAIN: stall_fetch=1, pc_write=0, bubble=1 until all slots invalid and br_taken=0.
REQ-019 DRAIN -> PUSH_PC (push_pc=1, 1 cycle) -> PUSH_FLAGS (push_flags=1, 1 cycle) -> VECTOR (load_vector=1, irq_ack=1, 1 cycle) -> IDLE.
REQ-020 irq asserted outside IDLE SHALL set irq_pending; cleared on entry to DRAIN; one interrupt serviced per sequence.
REQ-021 br_taken during DRAIN SHALL flush and extend DRAIN; push/vector states ignore load-use stall.
REQ-022 Outputs SHALL be combinational from state and slots; pc_write = 1 whenever no stall condition.

Reset
REQ-023 rst SHALL clear all slots, irq_pending, FSM to IDLE; during rst all outputs 0 including pc_write.
REQ-024 rst mid-sequence SHALL abort it with no further push_pc/push_flags/load_vector pulses.

Structure
REQ-025 FSM state enum and slot struct SHALL live in shared package pipeline_pkg.
REQ-026 One sub-module natural: hazard_fwd_match (per-operand priority match over slots), instantiated twice.

Verification (defaults)
REQ-027 Slot0 writes R3 (ALU), decode reads rsrc=R3 -> fwd_sel_src=1, no stall.
REQ-028 Load to R2 in slot0, decode reads R2 -> one cycle bubble=1, pc_write=0; next cycle fwd_sel=2.
REQ-029 R5 written in slot0 and slot2, decode reads R5 -> fwd_sel=1 (youngest wins).
REQ-030 br_taken=1 with decode writing R4 -> flush_fetch=flush_decode=1; next cycle slot0.valid=0.
REQ-031 irq pulse with 3 valid slots -> 3 DRAIN cycles, then push_pc, push_flags, load_vector+irq_ack in consecutive cycles; second irq during PUSH_PC serviced afterwards.
REQ-032 rst asserted in PUSH_FLAGS -> outputs 0, next cycle IDLE, no load_vector.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the hazard scoreboard: interrupt-sequence states and in-flight slot record.
// Slot addresses are stored at a fixed width so one type serves any REG_COUNT up to 256.
package pipeline_pkg;

    localparam int SLOT_AW = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_PC,
        PUSH_FLAGS,
        VECTOR
    } irq_state_e;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] addr;
        logic               is_load;
    } slot_t;

    function automatic slot_t make_slot(input logic valid, input logic [SLOT_AW-1:0] addr,
                                        input logic is_load);
        slot_t s;
        s.valid   = valid;
        s.addr    = addr;
        s.is_load = is_load;
        return s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/branch/interrupt inputs and the hazard-control outputs between pipeline and scoreboard.
// master = pipeline side, slave = scoreboard side.
interface hazard_scoreboard_if #(
    parameter int REG_COUNT  = 8,
    parameter int PIPE_DEPTH = 3
);
    localparam int REG_AW = $clog2(REG_COUNT);
    localparam int FWD_W  = $clog2(PIPE_DEPTH + 1);

    logic              dec_valid;
    logic [REG_AW-1:0] dec_rsrc;
    logic [REG_AW-1:0] dec_rdst;
    logic              dec_rsrc_used;
    logic              dec_rdst_used;
    logic              dec_wr_en;
    logic [REG_AW-1:0] dec_wr_addr;
    logic              dec_is_load;
    logic              br_taken;
    logic              irq;

    logic              pc_write;
    logic              stall_fetch;
    logic              flush_fetch;
    logic              flush_decode;
    logic              bubble;
    logic [FWD_W-1:0]  fwd_sel_src;
    logic [FWD_W-1:0]  fwd_sel_dst;
    logic              push_pc;
    logic              push_flags;
    logic              load_vector;
    logic              irq_ack;

    modport master (
        output dec_valid, dec_rsrc, dec_rdst, dec_rsrc_used, dec_rdst_used,
               dec_wr_en, dec_wr_addr, dec_is_load, br_taken, irq,
        input  pc_write, stall_fetch, flush_fetch, flush_decode, bubble,
               fwd_sel_src, fwd_sel_dst, push_pc, push_flags, load_vector, irq_ack
    );

    modport slave (
        input  dec_valid, dec_rsrc, dec_rdst, dec_rsrc_used, dec_rdst_used,
               dec_wr_en, dec_wr_addr, dec_is_load, br_taken, irq,
        output pc_write, stall_fetch, flush_fetch, flush_decode, bubble,
               fwd_sel_src, fwd_sel_dst, push_pc, push_flags, load_vector, irq_ack
    );

endinterface

// File: rtl/hazard_fwd_match.sv
// Per-operand forwarding match: youngest (lowest-index) valid slot writing the operand wins.
// Purely combinational; flags a load-use hazard when that slot's load result is not yet available.
module hazard_fwd_match
    import pipeline_pkg::*;
#(
    parameter int PIPE_DEPTH    = 3,
    parameter int LOAD_FWD_SLOT = 1,
    parameter int REG_AW        = 3,
    parameter int FWD_W         = 2
) (
    input  slot_t [PIPE_DEPTH-1:0] slots_i,
    input  logic [REG_AW-1:0]      reg_i,
    input  logic                   used_i,
    output logic [FWD_W-1:0]       sel_o,
    output logic                   load_stall_o
);

    always_comb begin
        sel_o        = '0;
        load_stall_o = 1'b0;
        // Walk oldest to youngest so the lowest matching index is the last one written.
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (used_i && slots_i[k].valid && slots_i[k].addr == SLOT_AW'(reg_i)) begin
                sel_o        = FWD_W'(k + 1);
                load_stall_o = slots_i[k].is_load && (k < LOAD_FWD_SLOT);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes for forwarding/load-use stalls and sequences interrupt entry.
// Outputs are combinational from current state and slots; a branch flush overrides any stall.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_COUNT     = 8,
    parameter int PIPE_DEPTH    = 3,
    parameter int LOAD_FWD_SLOT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_scoreboard_if.slave   hz
);

    localparam int REG_AW = $clog2(REG_COUNT);
    localparam int FWD_W  = $clog2(PIPE_DEPTH + 1);

    slot_t [PIPE_DEPTH-1:0] slots_q, slots_d;
    irq_state_e             state_q, state_d;
    logic                   irq_pending_q, irq_pending_d;

    logic             src_stall, dst_stall, load_use, all_empty, hold;
    logic [FWD_W-1:0] src_sel, dst_sel;
    logic             push_pc_c, push_flags_c, load_vector_c, irq_ack_c;

    hazard_fwd_match #(
        .PIPE_DEPTH   (PIPE_DEPTH),
        .LOAD_FWD_SLOT(LOAD_FWD_SLOT),
        .REG_AW       (REG_AW),
        .FWD_W        (FWD_W)
    ) u_match_src (
        .slots_i     (slots_q),
        .reg_i       (hz.dec_rsrc),
        .used_i      (hz.dec_rsrc_used),
        .sel_o       (src_sel),
        .load_stall_o(src_stall)
    );

    hazard_fwd_match #(
        .PIPE_DEPTH   (PIPE_DEPTH),
        .LOAD_FWD_SLOT(LOAD_FWD_SLOT),
        .REG_AW       (REG_AW),
        .FWD_W        (FWD_W)
    ) u_match_dst (
        .slots_i     (slots_q),
        .reg_i       (hz.dec_rdst),
        .used_i      (hz.dec_rdst_used),
        .sel_o       (dst_sel),
        .load_stall_o(dst_stall)
    );

    assign load_use = src_stall | dst_stall;

    always_comb begin
        all_empty = 1'b1;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (slots_q[k].valid) all_empty = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        irq_pending_d = irq_pending_q;
        hold          = 1'b0;
        push_pc_c     = 1'b0;
        push_flags_c  = 1'b0;
        load_vector_c = 1'b0;
        irq_ack_c     = 1'b0;

        // A request arriving mid-sequence is remembered and serviced by the next sequence.
        if (hz.irq && state_q != IDLE) irq_pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                hold = load_use;
                if (hz.irq || irq_pending_q) begin
                    state_d       = DRAIN;
                    irq_pending_d = 1'b0;
                end
            end
            DRAIN: begin
                hold = 1'b1;
                if (all_empty && !hz.br_taken) state_d = PUSH_PC;
            end
            PUSH_PC: begin
                hold      = 1'b1;
                push_pc_c = 1'b1;
                state_d   = PUSH_FLAGS;
            end
            PUSH_FLAGS: begin
                hold         = 1'b1;
                push_flags_c = 1'b1;
                state_d      = VECTOR;
            end
            VECTOR: begin
                hold          = 1'b1;
                load_vector_c = 1'b1;
                irq_ack_c     = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slots_d[0] = make_slot(hz.dec_valid && hz.dec_wr_en && !hold && !hz.br_taken,
                               SLOT_AW'(hz.dec_wr_addr), hz.dec_is_load);
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            slots_d[k] = slots_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots_q       <= '0;
            state_q       <= IDLE;
            irq_pending_q <= 1'b0;
        end else begin
            slots_q       <= slots_d;
            state_q       <= state_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    always_comb begin
        hz.flush_fetch  = hz.br_taken;
        hz.flush_decode = hz.br_taken;
        hz.stall_fetch  = hold && !hz.br_taken;
        hz.bubble       = hold && !hz.br_taken;
        hz.pc_write     = !(hold && !hz.br_taken);
        hz.fwd_sel_src  = src_sel;
        hz.fwd_sel_dst  = dst_sel;
        hz.push_pc      = push_pc_c;
        hz.push_flags   = push_flags_c;
        hz.load_vector  = load_vector_c;
        hz.irq_ack      = irq_ack_c;
        if (rst_i) begin
            hz.flush_fetch  = 1'b0;
            hz.flush_decode = 1'b0;
            hz.stall_fetch  = 1'b0;
            hz.bubble       = 1'b0;
            hz.pc_write     = 1'b0;
            hz.fwd_sel_src  = '0;
            hz.fwd_sel_dst  = '0;
            hz.push_pc      = 1'b0;
            hz.push_flags   = 1'b0;
            hz.load_vector  = 1'b0;
            hz.irq_ack      = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, branch flush, interrupt sequencing, reset abort.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_COUNT(8), .PIPE_DEPTH(3)) hz_bus ();

    hazard_scoreboard #(
        .REG_COUNT    (8),
        .PIPE_DEPTH   (3),
        .LOAD_FWD_SLOT(1)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .hz   (hz_bus)
    );

    // {stall_fetch, push_pc, push_flags, load_vector, irq_ack} per cycle after the irq pulse
    logic [4:0] seq_exp [12] = '{5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b10100, 5'b10011,
                                 5'b00000, 5'b10000, 5'b11000, 5'b10100, 5'b10011, 5'b00000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic we, input logic [2:0] wa, input logic ld,
                           input logic rsu, input logic [2:0] rs, input logic rdu,
                           input logic [2:0] rd);
        hz_bus.dec_valid     = v;
        hz_bus.dec_wr_en     = we;
        hz_bus.dec_wr_addr   = wa;
        hz_bus.dec_is_load   = ld;
        hz_bus.dec_rsrc_used = rsu;
        hz_bus.dec_rsrc      = rs;
        hz_bus.dec_rdst_used = rdu;
        hz_bus.dec_rdst      = rd;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    function automatic logic [31:0] seq_obs();
        return 32'({hz_bus.stall_fetch, hz_bus.push_pc, hz_bus.push_flags,
                    hz_bus.load_vector, hz_bus.irq_ack});
    endfunction

    initial begin
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        hz_bus.br_taken = 1'b0;
        hz_bus.irq      = 1'b0;

        // Reset: outputs forced low even with a branch and decode activity present
        repeat (2) @(posedge clk);
        #1;
        hz_bus.br_taken = 1'b1;
        set_dec(1, 1, 3, 0, 1, 3, 0, 0);
        #1;
        check("rst_pc_write", 32'(hz_bus.pc_write), 0);
        check("rst_flush_fetch", 32'(hz_bus.flush_fetch), 0);
        check("rst_bubble", 32'(hz_bus.bubble), 0);
        check("rst_fwd_src", 32'(hz_bus.fwd_sel_src), 0);
        rst = 1'b0;
        hz_bus.br_taken = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);

        // ALU result in slot0 forwards with no stall
        tick(); set_dec(1, 1, 3, 0, 0, 0, 0, 0); #1;
        check("idle_pc_write", 32'(hz_bus.pc_write), 1);
        check("empty_fwd_src", 32'(hz_bus.fwd_sel_src), 0);
        tick(); set_dec(1, 0, 0, 0, 1, 3, 1, 7); #1;
        check("alu_fwd_src", 32'(hz_bus.fwd_sel_src), 1);
        check("alu_fwd_dst_miss", 32'(hz_bus.fwd_sel_dst), 0);
        check("alu_no_stall", 32'(hz_bus.stall_fetch), 0);
        check("alu_no_bubble", 32'(hz_bus.bubble), 0);

        // Load-use: one bubble, then forward from slot1
        nop(3);
        tick(); set_dec(1, 1, 2, 1, 0, 0, 0, 0); #1;
        tick(); set_dec(1, 1, 6, 0, 1, 2, 0, 0); #1;
        check("lu_bubble", 32'(hz_bus.bubble), 1);
        check("lu_pc_write", 32'(hz_bus.pc_write), 0);
        check("lu_stall", 32'(hz_bus.stall_fetch), 1);
        check("lu_sel_slot0", 32'(hz_bus.fwd_sel_src), 1);
        tick(); #1;
        check("lu_after_bubble", 32'(hz_bus.bubble), 0);
        check("lu_after_pc_write", 32'(hz_bus.pc_write), 1);
        check("lu_after_fwd", 32'(hz_bus.fwd_sel_src), 2);
        // Load now in slot2 (forwardable) and the held ALU op in slot0
        tick(); set_dec(1, 0, 0, 0, 1, 2, 1, 6); #1;
        check("ld_slot2_fwd", 32'(hz_bus.fwd_sel_src), 3);
        check("ld_slot2_no_stall", 32'(hz_bus.stall_fetch), 0);
        check("dst_fwd_slot0", 32'(hz_bus.fwd_sel_dst), 1);

        // Youngest writer wins
        nop(3);
        tick(); set_dec(1, 1, 5, 0, 0, 0, 0, 0);
        tick(); set_dec(1, 1, 1, 0, 0, 0, 0, 0);
        tick(); set_dec(1, 1, 5, 0, 0, 0, 0, 0);
        tick(); set_dec(1, 0, 0, 0, 1, 5, 1, 1); #1;
        check("youngest_src", 32'(hz_bus.fwd_sel_src), 1);
        check("mid_dst", 32'(hz_bus.fwd_sel_dst), 2);
        set_dec(1, 0, 0, 0, 0, 5, 1, 1); #1;
        check("unused_src", 32'(hz_bus.fwd_sel_src), 0);

        // Branch flush drops the decode instruction
        nop(3);
        tick(); set_dec(1, 1, 4, 0, 0, 0, 0, 0); hz_bus.br_taken = 1'b1; #1;
        check("br_flush_fetch", 32'(hz_bus.flush_fetch), 1);
        check("br_flush_decode", 32'(hz_bus.flush_decode), 1);
        check("br_pc_write", 32'(hz_bus.pc_write), 1);
        tick(); hz_bus.br_taken = 1'b0; set_dec(1, 0, 0, 0, 1, 4, 0, 0); #1;
        check("br_slot0_empty", 32'(hz_bus.fwd_sel_src), 0);
        check("br_flush_clear", 32'(hz_bus.flush_fetch), 0);

        // Interrupt with three valid slots; second irq arrives during PUSH_PC
        nop(3);
        tick(); set_dec(1, 1, 1, 0, 0, 0, 0, 0);
        tick(); set_dec(1, 1, 2, 0, 0, 0, 0, 0);
        tick(); set_dec(1, 1, 3, 0, 0, 0, 0, 0);
        tick(); set_dec(0, 0, 0, 0, 0, 0, 0, 0); hz_bus.irq = 1'b1; #1;
        check("irq_idle_pc_write", 32'(hz_bus.pc_write), 1);
        check("irq_idle_no_push", 32'(hz_bus.push_pc), 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            hz_bus.irq = (i == 4);
            #1;
            check($sformatf("irq_seq_c%0d", i), seq_obs(), 32'(seq_exp[i-1]));
        end

        // Branch during DRAIN flushes and extends DRAIN by a cycle
        tick(); hz_bus.irq = 1'b1; #1;
        tick(); hz_bus.irq = 1'b0; hz_bus.br_taken = 1'b1; #1;
        check("drain_br_flush", 32'(hz_bus.flush_fetch), 1);
        check("drain_br_no_stall", 32'(hz_bus.stall_fetch), 0);
        tick(); hz_bus.br_taken = 1'b0; #1;
        check("drain_ext_stall", 32'(hz_bus.stall_fetch), 1);
        check("drain_ext_no_push", 32'(hz_bus.push_pc), 0);
        tick(); #1;
        check("drain_ext_push_pc", 32'(hz_bus.push_pc), 1);
        tick(); tick(); #1;
        check("drain_ext_vector", 32'(hz_bus.load_vector), 1);

        // Reset in PUSH_FLAGS aborts the sequence
        tick(); hz_bus.irq = 1'b1; #1;
        tick(); hz_bus.irq = 1'b0; #1;
        tick(); #1;
        check("abort_push_pc", 32'(hz_bus.push_pc), 1);
        tick(); rst = 1'b1; #1;
        check("abort_rst_push_flags", 32'(hz_bus.push_flags), 0);
        check("abort_rst_pc_write", 32'(hz_bus.pc_write), 0);
        check("abort_rst_stall", 32'(hz_bus.stall_fetch), 0);
        tick(); rst = 1'b0; #1;
        check("abort_idle_vector", 32'(hz_bus.load_vector), 0);
        check("abort_idle_pc_write", 32'(hz_bus.pc_write), 1);
        check("abort_idle_stall", 32'(hz_bus.stall_fetch), 0);
        tick(); #1;
        check("abort_no_vector", 32'(hz_bus.load_vector), 0);
        check("abort_no_ack", 32'(hz_bus.irq_ack), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
